// File: rtl/mem_burst_reader_pkg.sv
// Shared state encoding and read-buffer constants for mem_burst_reader and fifo2x8.
package mem_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_FIFO_CW    = 2;

  typedef logic [RD_FIFO_CW-1:0] occ_t;

  localparam occ_t RD_FIFO_FULL_OCC = occ_t'(RD_FIFO_DEPTH);

endpackage

// File: rtl/mem_burst_reader_fifo2x8.sv
// fifo2x8: two-entry byte FIFO with push/pop/full/empty and a synchronous flush.
// Push and pop in the same cycle are accepted together, also when full.
module fifo2x8
  import mem_burst_reader_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem_q [RD_FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  occ_t       count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != RD_FIFO_FULL_OCC) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + occ_t'(do_push) - occ_t'(do_pop);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == RD_FIFO_FULL_OCC);
  assign empty = (count_q == '0);

endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: strobed burst reads from a synchronous memory streamed out on valid/ready.
// Optional MEM_READER_ABORT_EN adds an 'abort' input that cancels a burst without a done pulse.
module mem_burst_reader
  import mem_burst_reader_pkg::*;
#(
  parameter int AW = 13,
  parameter int LW = 13
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] startAddr,
  input  logic [LW-1:0] length,
`ifdef MEM_READER_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] memAddr,
  output logic          memStrobe,
  input  logic [7:0]    memData,
  output logic [7:0]    outData,
  output logic          outValid,
  input  logic          outReady
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          pending_q, pending_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          issue;
  logic          abort_req;
  occ_t          occ;
  occ_t          occ_after_pop;
  occ_t          slots_used;

`ifdef MEM_READER_ABORT_EN
  assign abort_req = abort && (state_q != ST_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign outValid = !fifo_empty;
  assign pop      = outValid && outReady;

  // A byte leaving this cycle frees its slot, which keeps one read per clock going.
  assign occ           = fifo_full ? RD_FIFO_FULL_OCC : (fifo_empty ? occ_t'(0) : occ_t'(1));
  assign occ_after_pop = occ - occ_t'(pop);
  assign slots_used    = occ_after_pop + occ_t'(pending_q);

  assign issue = (state_q == ST_RUN) && (rem_q != '0) &&
                 (slots_used < RD_FIFO_FULL_OCC) && !abort_req;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    pending_d = issue;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = startAddr;
          rem_d   = length;
          state_d = (length == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LW'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the last byte is handed over, so done follows it by one cycle.
        if (!pending_q && (occ_after_pop == '0)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_req) begin
      state_d   = ST_IDLE;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      pending_q <= pending_d;
    end
  end

  fifo2x8 u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (abort_req),
    .push   (pending_q),
    .pop    (pop),
    .din    (memData),
    .dout   (outData),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign memAddr   = addr_q;
  assign memStrobe = issue;

endmodule
